// File: rtl/byte_encode.sv
// Kyber ByteEncode_l packer: 256 coefficients of l bits -> 4*l little-endian 64-bit words.
// Optional lane range check is compiled in with BYTE_ENCODE_RANGE_CHK_EN.
module byte_encode #(
    parameter int BUF_W  = 128,
    parameter int N_COEF = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [3:0]  i_l,
    input  logic [63:0] i_coeffs,
    input  logic        i_coeffs_valid,
    output logic        o_coeffs_ready,
    output logic [63:0] o_bytes,
    output logic        o_bytes_valid,
    input  logic        i_bytes_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_range_err
);
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [6:0] BEATS = 7'(N_COEF / 4);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         l_q, l_d;
    logic [BUF_W-1:0]   acc_q, acc_d, acc_base;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_base;
    logic [6:0]         in_cnt_q, in_cnt_d;
    logic [5:0]         out_cnt_q, out_cnt_d;
    logic [5:0]         words_total;
    logic [47:0]        beat_bits;
    logic [15:0]        lane_mask;
    logic               push, pop;

    function automatic logic l_legal(input logic [3:0] l);
        return (l == 4'd1) || (l == 4'd4) || (l == 4'd5) ||
               (l == 4'd10) || (l == 4'd11) || (l == 4'd12);
    endfunction

    assign words_total    = {l_q, 2'b00};
    assign o_bytes        = acc_q[63:0];
    assign o_bytes_valid  = (state_q == S_RUN) && (fill_q >= FILL_W'(64));
    assign o_coeffs_ready = (state_q == S_RUN) && (in_cnt_q < BEATS) &&
                            ((fill_q < FILL_W'(64)) || i_bytes_ready);
    assign o_busy         = (state_q == S_RUN);
    assign o_done         = (state_q == S_DONE);
    assign push           = i_coeffs_valid && o_coeffs_ready;
    assign pop            = o_bytes_valid && i_bytes_ready;

    // Lane k occupies bits [k*l +: l] of the beat; bits above l are dropped.
    always_comb begin
        beat_bits = '0;
        lane_mask = 16'((17'd1 << l_q) - 17'd1);
        for (int k = 0; k < 4; k++) begin
            beat_bits = beat_bits | (48'(i_coeffs[16*k +: 16] & lane_mask) << (k * int'(l_q)));
        end
    end

    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        acc_base  = pop ? (acc_q >> 64) : acc_q;
        fill_base = pop ? (fill_q - FILL_W'(64)) : fill_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && l_legal(i_l)) begin
                    l_d       = i_l;
                    acc_d     = '0;
                    fill_d    = '0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // New bits land just above what remains after this cycle's pop.
                acc_d  = push ? (acc_base | (BUF_W'(beat_bits) << fill_base)) : acc_base;
                fill_d = fill_base + (push ? FILL_W'({l_q, 2'b00}) : FILL_W'(0));
                if (push) in_cnt_d = in_cnt_q + 7'd1;
                if (pop) begin
                    out_cnt_d = out_cnt_q + 6'd1;
                    if (out_cnt_q == words_total - 6'd1) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            l_q       <= '0;
            acc_q     <= '0;
            fill_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef BYTE_ENCODE_RANGE_CHK_EN
    logic        err_q, err_d;
    logic        lane_bad;
    logic [16:0] lane_limit;

    // l=12 coefficients are reduced mod q=3329, not mod 2^12.
    always_comb begin
        lane_limit = (l_q == 4'd12) ? 17'd3329 : (17'd1 << l_q);
        lane_bad   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ({1'b0, i_coeffs[16*k +: 16]} >= lane_limit) lane_bad = 1'b1;
        end
        err_d = err_q;
        if ((state_q == S_IDLE) && i_start) err_d = 1'b0;
        if (push && lane_bad) err_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign o_range_err = err_q;
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_encode.sv
// Bench for byte_encode: table of whole-polynomial runs checked against a bit-stream model,
// plus illegal-start and mid-run reset sequences.
module tb_byte_encode;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [3:0]  i_l;
    logic [63:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_coeffs_ready;
    logic [63:0] o_bytes;
    logic        o_bytes_valid;
    logic        i_bytes_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_range_err;

    byte_encode dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_l            (i_l),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_bytes        (o_bytes),
        .o_bytes_valid  (o_bytes_valid),
        .i_bytes_ready  (i_bytes_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_range_err    (o_range_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] coef [256];
    logic        stream [3072];
    logic        bad_beat [64];
    logic [63:0] exp_q [$];

    typedef struct {
        int          l;
        int          pat;
        int          vmode;
        int          rmode;
        logic        chk_w0;
        logic [63:0] w0;
        int          abort_at;
    } row_t;

    row_t rows [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic lane_out_of_range(input logic [15:0] v, input int l);
`ifdef BYTE_ENCODE_RANGE_CHK_EN
        if (l == 12) return v >= 16'd3329;
        return int'(v) >= (1 << l);
`else
        return 1'b0;
`endif
    endfunction

    task automatic fill_coefs(input int l, input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0: coef[i] = 16'd1;
                1: coef[i] = 16'(i);
                2: coef[i] = 16'((i % 4) + 1);
                3: coef[i] = 16'(i % 32);
                4: coef[i] = (l == 12) ? 16'($urandom_range(0, 3328)) : 16'($urandom_range(0, (1 << l) - 1));
                5: coef[i] = 16'($urandom);
                default: coef[i] = (i == 12) ? 16'h0400 : 16'(i % (1 << l));
            endcase
        end
    endtask

    // Reference: lay every coefficient's low l bits into one flat bit stream, cut into 64-bit words.
    task automatic build_model(input int l);
        logic [63:0] w;
        exp_q.delete();
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < l; j++)
                stream[i * l + j] = coef[i][j];
        for (int n = 0; n < 4 * l; n++) begin
            for (int b = 0; b < 64; b++) w[b] = stream[64 * n + b];
            exp_q.push_back(w);
        end
        for (int b = 0; b < 64; b++) begin
            bad_beat[b] = 1'b0;
            for (int k = 0; k < 4; k++)
                if (lane_out_of_range(coef[4 * b + k], l)) bad_beat[b] = 1'b1;
        end
    endtask

    task automatic start_run(input int l);
        i_start = 1'b1;
        i_l     = 4'(l);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_l     = 4'($urandom_range(0, 15));
    endtask

    task automatic run_poly(input row_t r);
        int          beat = 0, nout = 0, cyc = 0, stall_cnt = 0, nr_run = 0, max_nr = 0;
        logic        err_exp = 1'b0, err_pend = 1'b0, held_v = 1'b0, push, pop;
        logic [63:0] held = '0, want;
        fill_coefs(r.l, r.pat);
        build_model(r.l);
        start_run(r.l);
        while (nout < 4 * r.l && cyc < 5000) begin
            if (r.abort_at > 0 && beat >= r.abort_at) begin
                i_coeffs_valid = 1'b0;
                i_rst = 1'b1;
                @(posedge i_clk); #1;
                i_rst = 1'b0;
                @(negedge i_clk);
                check("abort_busy", 64'(o_busy), 64'd0);
                check("abort_bytes", o_bytes, 64'd0);
                check("abort_valid", 64'(o_bytes_valid), 64'd0);
                check("abort_ready", 64'(o_coeffs_ready), 64'd0);
                check("abort_err", 64'(o_range_err), 64'd0);
                for (int c = 0; c < 5; c++) begin
                    check("abort_no_done", 64'(o_done), 64'd0);
                    @(negedge i_clk);
                end
                @(posedge i_clk); #1;
                return;
            end
            i_coeffs_valid = (beat < 64) && (r.vmode == 0 || $urandom_range(0, 3) != 0);
            i_coeffs = (beat < 64) ? {coef[4*beat+3], coef[4*beat+2], coef[4*beat+1], coef[4*beat]} : '0;
            case (r.rmode)
                0:       i_bytes_ready = 1'b1;
                1:       i_bytes_ready = ($urandom_range(0, 3) != 0);
                default: i_bytes_ready = !(nout == 2 && stall_cnt < 10);
            endcase
            if (r.rmode == 2 && nout == 2 && stall_cnt < 10) stall_cnt++;
            @(negedge i_clk);
            check("range_err", 64'(o_range_err), 64'(err_exp));
            if (o_bytes_valid && !i_bytes_ready) begin
                if (held_v) check("stall_hold", o_bytes, held);
                check("stall_ready_low", 64'(o_coeffs_ready), 64'd0);
                held   = o_bytes;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            push = i_coeffs_valid && o_coeffs_ready;
            pop  = o_bytes_valid && i_bytes_ready;
            if (pop) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                check($sformatf("word%0d", nout), o_bytes, want);
                if (nout == 0 && r.chk_w0) check("word0_const", o_bytes, r.w0);
                nout++;
            end
            if (push) begin
                if (bad_beat[beat]) err_pend = 1'b1;
                beat++;
            end
            if (beat < 64 && !o_coeffs_ready) nr_run++;
            else nr_run = 0;
            if (nr_run > max_nr) max_nr = nr_run;
            @(posedge i_clk); #1;
            err_exp = err_pend;
            cyc++;
        end
        i_coeffs_valid = 1'b0;
        i_bytes_ready  = 1'b1;
        if (cyc >= 5000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words expected %0d", nout, 4 * r.l);
            return;
        end
        check("beats_used", 64'(beat), 64'd64);
        check("words_left", 64'(exp_q.size()), 64'd0);
        if (r.vmode == 0 && r.rmode == 0) check("ready_gap", 64'(max_nr <= 1), 64'd1);
        @(negedge i_clk);
        check("done_pulse", 64'(o_done), 64'd1);
        check("busy_in_done", 64'(o_busy), 64'd0);
        check("valid_in_done", 64'(o_bytes_valid), 64'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("done_cleared", 64'(o_done), 64'd0);
        check("idle_busy", 64'(o_busy), 64'd0);
        check("err_sticky", 64'(o_range_err), 64'(err_exp));
        @(posedge i_clk); #1;
    endtask

    task automatic illegal_start();
        i_coeffs_valid = 1'b1;
        i_bytes_ready  = 1'b1;
        i_start = 1'b1;
        i_l     = 4'd7;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            check("illegal_busy", 64'(o_busy), 64'd0);
            check("illegal_valid", 64'(o_bytes_valid), 64'd0);
            check("illegal_ready", 64'(o_coeffs_ready), 64'd0);
            check("illegal_done", 64'(o_done), 64'd0);
            @(posedge i_clk); #1;
        end
        i_coeffs_valid = 1'b0;
    endtask

    initial begin
        rows[0]  = '{l: 1,  pat: 0, vmode: 0, rmode: 0, chk_w0: 1'b1, w0: 64'hFFFF_FFFF_FFFF_FFFF, abort_at: 0};
        rows[1]  = '{l: 12, pat: 1, vmode: 0, rmode: 0, chk_w0: 1'b1, w0: 64'h5004_0030_0200_1000, abort_at: 0};
        rows[2]  = '{l: 4,  pat: 2, vmode: 0, rmode: 2, chk_w0: 1'b1, w0: 64'h4321_4321_4321_4321, abort_at: 0};
        rows[3]  = '{l: 5,  pat: 3, vmode: 0, rmode: 0, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[4]  = '{l: 10, pat: 1, vmode: 0, rmode: 0, chk_w0: 1'b0, w0: 64'd0, abort_at: 20};
        rows[5]  = '{l: 10, pat: 1, vmode: 0, rmode: 0, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[6]  = '{l: 10, pat: 6, vmode: 1, rmode: 1, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[7]  = '{l: 11, pat: 4, vmode: 1, rmode: 1, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[8]  = '{l: 1,  pat: 4, vmode: 1, rmode: 1, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[9]  = '{l: 12, pat: 4, vmode: 1, rmode: 1, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[10] = '{l: 5,  pat: 5, vmode: 1, rmode: 1, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};
        rows[11] = '{l: 4,  pat: 4, vmode: 1, rmode: 1, chk_w0: 1'b0, w0: 64'd0, abort_at: 0};

        i_rst = 1'b1;
        i_start = 1'b0;
        i_l = 4'd0;
        i_coeffs = '0;
        i_coeffs_valid = 1'b0;
        i_bytes_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_bytes", o_bytes, 64'd0);
        check("rst_valid", 64'(o_bytes_valid), 64'd0);
        check("rst_ready", 64'(o_coeffs_ready), 64'd0);
        check("rst_err", 64'(o_range_err), 64'd0);
        @(posedge i_clk); #1;

        for (int r = 0; r < 12; r++) begin
            if (r == 3) illegal_start();
            run_poly(rows[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
